// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one RV32 ALU between two requesters (0 = core execute
//                stage, 1 = auxiliary/debug engine). Grants round-robin,
//                strobes the ALU operand registers, waits out multiply
//                latency, captures result + flags and returns them on a
//                valid/ready response channel.
//  Ports       : clock, reset              - clock / async active-high reset
//                req_valid/req_ready [1:0] - request handshake per requester
//                req_a/req_b [63:0]        - operands ([31:0] = requester 0)
//                req_op [9:0]              - op codes ([4:0] = requester 0)
//                rsp_valid/rsp_ready [1:0] - response handshake per requester
//                rsp_result [31:0]         - captured ALU result
//                rsp_cnzv [3:0]            - captured ALU flags {v,n,z,c}
//                alu_write                 - ALU operand-register load strobe
//                alu_a/alu_b/alu_operation - operands and op code to ALU
//                alu_result/alu_cnzv       - combinational ALU outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int MUL_WAIT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [9:0]  req_op,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_cnzv,
    output logic        alu_write,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_operation,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_cnzv
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_EXEC  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [3:0] c_MUL_WAIT = 4'(MUL_WAIT);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_owner;
    logic        r_last_served;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_op;
    logic [3:0]  r_wait;
    logic [31:0] r_result;
    logic [3:0]  r_cnzv;

    logic        w_accept;
    logic        w_grant_idx;
    logic        w_is_mul;
    logic        w_capture;
    logic        w_rsp_done;

    // Grant is only offered while idle; on contention the requester that was
    // not served last wins, so both sides alternate under sustained load.
    always_comb begin
        req_ready = 2'b00;
        if (r_state == c_IDLE) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = r_last_served ? 2'b01 : 2'b10;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign w_accept    = |(req_valid & req_ready);
    assign w_grant_idx = req_ready[1];

    // Op codes 8..11 are the multiply group (5'b010xx).
    assign w_is_mul    = (r_op[4:2] == 3'b010);
    assign w_capture   = (r_state == c_EXEC) && (!w_is_mul || (r_wait == 4'd0));
    assign w_rsp_done  = (r_state == c_RESP) && rsp_ready[r_owner];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)   w_state_next = c_ISSUE;
            c_ISSUE:                 w_state_next = c_EXEC;
            c_EXEC:  if (w_capture)  w_state_next = c_RESP;
            c_RESP:  if (w_rsp_done) w_state_next = c_IDLE;
            default:                 w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_owner       <= 1'b0;
            r_last_served <= 1'b1;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_wait        <= '0;
            r_result      <= '0;
            r_cnzv        <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_owner <= w_grant_idx;
                r_a     <= w_grant_idx ? req_a[63:32] : req_a[31:0];
                r_b     <= w_grant_idx ? req_b[63:32] : req_b[31:0];
                r_op    <= w_grant_idx ? req_op[9:5]  : req_op[4:0];
            end

            // Counter is armed as the ALU loads its operands; a multiply is
            // captured once it has run down to zero inside EXEC.
            if (r_state == c_ISSUE) begin
                r_wait <= w_is_mul ? c_MUL_WAIT : 4'd0;
            end else if ((r_state == c_EXEC) && (r_wait != 4'd0)) begin
                r_wait <= r_wait - 4'd1;
            end

            if (w_capture) begin
                r_result <= alu_result;
                r_cnzv   <= alu_cnzv;
            end

            if (w_rsp_done) begin
                r_last_served <= r_owner;
            end
        end
    end

    // Response data stays in its registers after RESP; rsp_valid alone
    // qualifies it.
    assign rsp_valid     = (r_state == c_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result    = r_result;
    assign rsp_cnzv      = r_cnzv;
    assign alu_write     = (r_state == c_ISSUE);
    assign alu_a         = r_a;
    assign alu_b         = r_b;
    assign alu_operation = r_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with an ALU stand-in
//                whose multiply results only become valid MUL_WAIT cycles
//                after the operand load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int MUL_WAIT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [9:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_cnzv;
    logic        alu_write;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_operation;
    logic [31:0] alu_result;
    logic [3:0]  alu_cnzv;

    int vectors     = 0;
    int miscompares = 0;
    int model_last  = 1;

    always #5 clock = ~clock;

    alu_arbiter #(.MUL_WAIT(MUL_WAIT)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_cnzv      (rsp_cnzv),
        .alu_write     (alu_write),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .alu_cnzv      (alu_cnzv)
    );

    // ALU behaviour: returns {result, v, n, z, c}.
    function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [63:0] p;
        logic [31:0] r;
        logic        c;
        logic        v;
        s = '0; p = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            5'd0:  begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                         v = (a[31] == b[31]) && (r[31] != a[31]); end
            5'd16: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                         v = (a[31] != b[31]) && (r[31] != a[31]); end
            5'd1:  r = a << b[4:0];
            5'd2:  r = {31'b0, $signed(a) < $signed(b)};
            5'd3:  r = {31'b0, a < b};
            5'd4:  r = a ^ b;
            5'd5:  r = a >> b[4:0];
            5'd21: r = 32'($signed(a) >>> b[4:0]);
            5'd6:  r = a | b;
            5'd7:  r = a & b;
            5'd8:  begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            5'd9:  begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            5'd10: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
            5'd11: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            default: r = '0;
        endcase
        return {r, v, r[31], (r == 32'd0), c};
    endfunction

    // ALU stand-in: registered operands, multiply output is garbage until
    // MUL_WAIT cycles after the load, so an early capture is visible.
    logic [31:0] s_a   = '0;
    logic [31:0] s_b   = '0;
    logic [4:0]  s_op  = '0;
    int          s_age = 0;
    logic [35:0] s_out;

    always @(posedge clock) begin
        if (alu_write) begin
            s_a   <= alu_a;
            s_b   <= alu_b;
            s_op  <= alu_operation;
            s_age <= 0;
        end else if (s_age < 1000) begin
            s_age <= s_age + 1;
        end
    end

    always_comb begin
        s_out = alu_fn(s_op, s_a, s_b);
        if ((s_op >= 5'd8) && (s_op <= 5'd11) && (s_age < MUL_WAIT)) begin
            alu_result = 32'hDEAD_BEEF;
            alu_cnzv   = 4'hF;
        end else begin
            alu_result = s_out[35:4];
            alu_cnzv   = s_out[3:0];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full transaction: grant check, issue check, latency, response, optional
    // backpressure with a non-owner rsp_ready pulse, response handshake.
    task automatic run_txn(input logic [1:0] valids,
                           input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] op0,
                           input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] op1,
                           input int delay, input int exp_own,
                           input logic [31:0] exp_res, input logic [3:0] exp_cnzv);
        logic [31:0] ea;
        logic [31:0] eb;
        logic [4:0]  eop;
        logic [1:0]  own_bit;
        logic [1:0]  other_bit;
        int n;
        int writes;
        int exp_lat;
        ea        = exp_own ? a1 : a0;
        eb        = exp_own ? b1 : b0;
        eop       = exp_own ? op1 : op0;
        own_bit   = exp_own ? 2'b10 : 2'b01;
        other_bit = exp_own ? 2'b01 : 2'b10;
        exp_lat   = ((eop >= 5'd8) && (eop <= 5'd11)) ? 3 + MUL_WAIT : 3;

        req_a = {a1, a0}; req_b = {b1, b0}; req_op = {op1, op0};
        req_valid = valids; rsp_ready = 2'b00;
        #1;
        chk("req_ready_grant", req_ready, own_bit);
        step();
        req_valid = req_valid & ~own_bit;
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_operation", alu_operation, eop);
        writes = 0;
        n = 1;
        while ((rsp_valid == 2'b00) && (n < 40)) begin
            if (alu_write) writes++;
            chk("req_ready_busy", req_ready, 2'b00);
            step();
            n++;
        end
        chk("latency", n, exp_lat);
        chk("alu_write_pulses", writes, 1);
        chk("rsp_valid", rsp_valid, own_bit);
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_cnzv", rsp_cnzv, exp_cnzv);

        for (int k = 0; k < delay; k++) begin
            rsp_ready = (k == 1) ? other_bit : 2'b00;
            req_valid = other_bit;
            step();
            chk("bp_rsp_valid", rsp_valid, own_bit);
            chk("bp_rsp_result", rsp_result, exp_res);
            chk("bp_req_ready", req_ready, 2'b00);
        end

        rsp_ready = own_bit;
        req_valid = 2'b00;
        step();
        rsp_ready = 2'b00;
        chk("rsp_valid_drop", rsp_valid, 2'b00);
        model_last = exp_own;
    endtask

    typedef struct {
        logic [1:0]  valids;
        logic [31:0] a0, b0;
        logic [4:0]  op0;
        logic [31:0] a1, b1;
        logic [4:0]  op1;
        int          delay;
        int          own;
        logic [31:0] res;
        logic [3:0]  cnzv;
    } vec_t;

    vec_t tbl[10];
    logic [4:0] ops[18];

    initial begin
        tbl[0] = '{2'b11, 32'd1, 32'd2, 5'd0, 32'hF0, 32'h0F, 5'd4, 0, 0, 32'd3, 4'b0000};
        tbl[1] = '{2'b11, 32'd1, 32'd2, 5'd0, 32'hF0, 32'h0F, 5'd4, 0, 1, 32'hFF, 4'b0000};
        tbl[2] = '{2'b11, 32'd1, 32'd2, 5'd0, 32'hF0, 32'h0F, 5'd4, 0, 0, 32'd3, 4'b0000};
        tbl[3] = '{2'b11, 32'd1, 32'd2, 5'd0, 32'hF0, 32'h0F, 5'd4, 0, 1, 32'hFF, 4'b0000};
        tbl[4] = '{2'b01, 32'd5, 32'd7, 5'd0, 32'd0, 32'd0, 5'd0, 0, 0, 32'd12, 4'b0000};
        tbl[5] = '{2'b01, 32'h10, 32'h10, 5'd16, 32'd0, 32'd0, 5'd0, 0, 0, 32'd0, 4'b0011};
        tbl[6] = '{2'b10, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd2, 5'd11, 10, 1, 32'd1, 4'b0000};
        tbl[7] = '{2'b01, 32'd3, 32'd4, 5'd12, 32'd0, 32'd0, 5'd0, 0, 0, 32'd0, 4'b0010};
        tbl[8] = '{2'b11, 32'hFFFF_FFFF, 32'd3, 5'd8, 32'd6, 32'd7, 5'd16, 2, 1, 32'hFFFF_FFFF, 4'b0100};
        tbl[9] = '{2'b11, 32'hFFFF_FFFF, 32'd3, 5'd8, 32'd6, 32'd7, 5'd16, 1, 0, 32'hFFFF_FFFD, 4'b0100};
        ops = '{5'd0, 5'd16, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd21, 5'd6, 5'd7,
                5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd20, 5'd31};

        reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req_a = '0; req_b = '0; req_op = '0;
        repeat (3) step();
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_cnzv", rsp_cnzv, 4'd0);
        chk("rst_alu_write", alu_write, 1'b0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_operation", alu_operation, 5'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].valids, tbl[i].a0, tbl[i].b0, tbl[i].op0,
                    tbl[i].a1, tbl[i].b1, tbl[i].op1,
                    tbl[i].delay, tbl[i].own, tbl[i].res, tbl[i].cnzv);
        end

        // Reset while a multiply sits in EXEC.
        req_a = {32'd0, 32'hFFFF_FFFF}; req_b = {32'd0, 32'd2}; req_op = {5'd0, 5'd11};
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        reset = 1'b1;
        #1;
        chk("arst_rsp_valid", rsp_valid, 2'b00);
        chk("arst_alu_write", alu_write, 1'b0);
        step();
        chk("arst_rsp_valid_next", rsp_valid, 2'b00);
        chk("arst_alu_write_next", alu_write, 1'b0);
        chk("arst_alu_a", alu_a, 32'd0);
        chk("arst_rsp_result", rsp_result, 32'd0);
        reset = 1'b0;
        model_last = 1;
        step();
        chk("arst_no_rsp", rsp_valid, 2'b00);
        run_txn(2'b11, 32'd9, 32'd1, 5'd16, 32'd1, 32'd1, 5'd0, 0, 0, 32'd8, 4'b0001);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  v;
            logic [31:0] a0, b0, a1, b1;
            logic [4:0]  op0, op1;
            logic [35:0] e;
            int own;
            v   = 2'($urandom_range(1, 3));
            a0  = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            op0 = ops[$urandom_range(0, 17)];
            op1 = ops[$urandom_range(0, 17)];
            if (v == 2'b11) own = (model_last == 1) ? 0 : 1;
            else            own = (v == 2'b10) ? 1 : 0;
            e = (own == 1) ? alu_fn(op1, a1, b1) : alu_fn(op0, a0, b0);
            run_txn(v, a0, b0, op0, a1, b1, op1, int'($urandom_range(0, 3)), own, e[35:4], e[3:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
